vending_ctrl_param: RTL and testbench
=====================================

# vending_ctrl_param

Parametrised vending-machine controller that merges coin accumulation, product selection and change return into one sequential block. It supports N products with per-product prices, a saturating credit register, optional per-product stock counters, cancel/refund, and change paid out serially, largest coin first. It sits between the coin acceptor/keypad front end and the dispenser actuators, replacing the fixed two-FSM vending datapath.

## Interface

**Parameters**
- `NUM_PROD`, default 4: number of products. Must be ≤ 2^`SEL_W`.
- `SEL_W`, default 2: width of the product index.
- `CREDIT_W`, default 6: width of the credit register.
- `MAX_CREDIT`, default 15: credit ceiling. Must be < 2^`CREDIT_W`.
- `PRICES`, default {6'd7,6'd6,6'd4,6'd3}: packed `NUM_PROD*CREDIT_W` vector. Product i occupies `[i*CREDIT_W +: CREDIT_W]`. Every price must be nonzero.
- `STOCK_W`, default 4: width of each stock counter.
- `STOCK_INIT`, default 3: stock loaded into every counter at reset.

**Ports**
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `moneda`  in  2  coin this cycle: 00 = none, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
- `seleccion`  in  `SEL_W`  product index; sampled only when `sel_valid` = 1.
- `sel_valid`  in  1  one-cycle selection strobe.
- `cancel`  in  1  one-cycle refund request.
- `producto`  out  `SEL_W`  index of the vended product; valid while `listo` = 1.
- `listo`  out  1  one-cycle vend pulse.
- `cambio`  out  2  coin being returned (same encoding as `moneda`); 00 when idle.
- `cambio_valid`  out  1  high for each returned coin.
- `credit`  out  `CREDIT_W`  current credit.
- `coin_rej`  out  1  one-cycle pulse: the coin presented in the previous cycle was refused.
- `deny`  out  1  one-cycle pulse: the selection in the previous cycle was refused.
- `sold_out`  out  `NUM_PROD`  bit i = 1 when the stock of product i is 0.

## Operation

**Reset.** All outputs 0, state IDLE, credit 0, every stock counter = `STOCK_INIT`. `sold_out` is therefore 0 unless `STOCK_INIT` = 0. Reset asserted mid-VEND or mid-CHANGE aborts the operation; the remaining credit is lost.

**IDLE.** Credit is 0.
- A coin loads credit and moves to CREDIT.
- `sel_valid` pulses `deny`.
- `cancel` is ignored.

**CREDIT.** Request priority is `cancel` > `sel_valid` > coin.
- **Cancel:** go to CHANGE; any coin presented in the same cycle is rejected.
- **Selection:** accepted when price(`seleccion`) ≤ credit, `seleccion` < `NUM_PROD`, and the product is not sold out. On acceptance go to VEND, latch the index, and reject any same-cycle coin. Otherwise pulse `deny`, stay in CREDIT, and still evaluate the coin.
- **Coin:** if credit + value > `MAX_CREDIT`, the coin is rejected and credit is unchanged. Otherwise credit += value.

**VEND.** Lasts one cycle.
- `listo` = 1 and `producto` = the latched index.
- Credit is reduced by the price.
- The stock counter of that product decrements.
- Next state is CHANGE if the remainder > 0, else IDLE.

**CHANGE.** Each cycle:
- Emit the largest coin (5, then 2, then 1) that is ≤ credit.
- Assert `cambio_valid` and subtract the coin value from credit.
- Return to IDLE on the cycle after credit reaches 0.

**Rejections outside CREDIT.** In VEND and CHANGE every coin is rejected and every `sel_valid` is denied; `cancel` is ignored.

**Arithmetic.**
- Credit arithmetic uses `CREDIT_W+1` bits internally; the sum never exceeds `MAX_CREDIT`.
- Stock counters never wrap below 0.

## Timing

- All outputs are registered.
- `listo` asserts 1 cycle after the accepted `sel_valid`.
- The first `cambio_valid` asserts 1 cycle after `listo`. For a cancel, it asserts 1 cycle after `cancel`.
- Change of C units takes ⌊C/5⌋ + ⌊(C mod 5)/2⌋ + (C mod 5 mod 2) cycles of consecutive `cambio_valid`.
- `coin_rej` and `deny` are asserted in the cycle following the offending input.
- `credit` reflects the new value 1 cycle after the coin or vend.
- `sold_out` updates in the cycle after the vend that empties a counter.

## Configuration

- **`VEND_STOCK_EN` defined:** per-product stock counters and `sold_out` exist as described; a sold-out selection is denied.
- **`VEND_STOCK_EN` not defined:** there are no stock counters, stock is unlimited, `sold_out` is tied to 0, and `STOCK_W`/`STOCK_INIT` are unused.

## Test plan

1. **Vend with change.** Coins 10, 10 → credit 4; select 0 (price 3). Expect `listo` = 1 with `producto` = 0; next cycle `cambio` = 01 with `cambio_valid`; then credit 0 and IDLE.
2. **Cancel refund.** Coins 11, 10 → credit 7; `cancel`. Expect `cambio` = 11, then 10, then idle; no `listo`.
3. **Insufficient credit.** Credit 4; select 3 (price 7). Expect a `deny` pulse and credit 4 held. Then insert 11 → credit 9; select 3 → `listo`, then `cambio` = 10.
4. **Saturation and collision.** Credit 14 + coin 11 → `coin_rej` and credit 14. Then, in one cycle, an accepted `sel_valid` for product 2 together with coin 01 → `listo` and `coin_rej`, followed by change 5 + 2 + 1.
5. **Stock exhaustion (`VEND_STOCK_EN`).** Three exact-credit vends of product 1 → `sold_out[1]` = 1. A fourth selection → `deny`; a refund follows on `cancel`.
6. **Reset mid-change.** With credit 8 in CHANGE after the first coin, assert `rst` for 1 cycle. All outputs go to 0, credit is 0, state is IDLE, and stock is reloaded to 3.

Source files
------------

// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: coin credit, product vend and serial change return.
// Optional per-product stock counters are compiled in with `define VEND_STOCK_EN.
module vending_ctrl_param #(
    parameter int                          NUM_PROD   = 4,
    parameter int                          SEL_W      = 2,
    parameter int                          CREDIT_W   = 6,
    parameter int                          MAX_CREDIT = 15,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES    = {6'd7, 6'd6, 6'd4, 6'd3},
    parameter int                          STOCK_W    = 4,
    parameter int                          STOCK_INIT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          moneda,
    input  logic [SEL_W-1:0]    seleccion,
    input  logic                sel_valid,
    input  logic                cancel,
    output logic [SEL_W-1:0]    producto,
    output logic                listo,
    output logic [1:0]          cambio,
    output logic                cambio_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_rej,
    output logic                deny,
    output logic [NUM_PROD-1:0] sold_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_CHANGE
    } state_t;

    typedef logic [CREDIT_W:0] cext_t;

    localparam cext_t MAX_EXT = cext_t'(MAX_CREDIT);

    if (NUM_PROD > (2 ** SEL_W) || MAX_CREDIT >= (2 ** CREDIT_W) ||
        STOCK_W < 1 || STOCK_INIT >= (2 ** STOCK_W)) begin : g_bad_params
        $error("vending_ctrl_param: inconsistent parameter set");
    end

    function automatic cext_t coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return cext_t'(1);
            2'b10:   return cext_t'(2);
            2'b11:   return cext_t'(5);
            default: return cext_t'(0);
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    producto_q, producto_d;
    logic                listo_q, listo_d;
    logic [1:0]          cambio_q, cambio_d;
    logic                cambio_valid_q, cambio_valid_d;
    logic                coin_rej_q, coin_rej_d;
    logic                deny_q, deny_d;

    logic [CREDIT_W-1:0] sel_price;
    logic                sel_known;
    logic                sel_empty;
    logic [1:0]          chg_code;
    logic [CREDIT_W-1:0] chg_val;

    // Price and sold-out lookup for the requested index; out-of-range indices stay unknown.
    always_comb begin
        sel_price = '0;
        sel_known = 1'b0;
        sel_empty = 1'b0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (seleccion == SEL_W'(i)) begin
                sel_known = 1'b1;
                sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_empty = sold_out[i];
            end
        end
    end

    // Largest returnable coin that still fits in the remaining credit.
    always_comb begin
        chg_code = 2'b00;
        chg_val  = '0;
        if (credit_q >= CREDIT_W'(5)) begin
            chg_code = 2'b11;
            chg_val  = CREDIT_W'(5);
        end else if (credit_q >= CREDIT_W'(2)) begin
            chg_code = 2'b10;
            chg_val  = CREDIT_W'(2);
        end else if (credit_q != '0) begin
            chg_code = 2'b01;
            chg_val  = CREDIT_W'(1);
        end
    end

    always_comb begin
        logic  coin_in;
        logic  coin_fits;
        cext_t coin_sum;

        state_d        = state_q;
        credit_d       = credit_q;
        producto_d     = '0;
        listo_d        = 1'b0;
        cambio_d       = 2'b00;
        cambio_valid_d = 1'b0;
        coin_rej_d     = 1'b0;
        deny_d         = 1'b0;

        coin_in   = (moneda != 2'b00);
        coin_sum  = {1'b0, credit_q} + coin_value(moneda);
        coin_fits = (coin_sum <= MAX_EXT);

        case (state_q)
            ST_IDLE: begin
                deny_d = sel_valid;
                if (coin_in) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end
            ST_CREDIT: begin
                if (cancel) begin
                    // First refund coin leaves on the same edge so it appears the cycle after cancel.
                    coin_rej_d     = coin_in;
                    cambio_d       = chg_code;
                    cambio_valid_d = (chg_val != '0);
                    credit_d       = credit_q - chg_val;
                    state_d        = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else if (sel_valid && sel_known && !sel_empty && (sel_price <= credit_q)) begin
                    listo_d    = 1'b1;
                    producto_d = seleccion;
                    credit_d   = credit_q - sel_price;
                    coin_rej_d = coin_in;
                    state_d    = ST_VEND;
                end else begin
                    deny_d = sel_valid;
                    if (coin_in) begin
                        if (coin_fits) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                        end else begin
                            coin_rej_d = 1'b1;
                        end
                    end
                end
            end
            ST_VEND, ST_CHANGE: begin
                coin_rej_d = coin_in;
                deny_d     = sel_valid;
                if (credit_q != '0) begin
                    cambio_d       = chg_code;
                    cambio_valid_d = 1'b1;
                    credit_d       = credit_q - chg_val;
                    state_d        = ST_CHANGE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            producto_q     <= '0;
            listo_q        <= 1'b0;
            cambio_q       <= 2'b00;
            cambio_valid_q <= 1'b0;
            coin_rej_q     <= 1'b0;
            deny_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            producto_q     <= producto_d;
            listo_q        <= listo_d;
            cambio_q       <= cambio_d;
            cambio_valid_q <= cambio_valid_d;
            coin_rej_q     <= coin_rej_d;
            deny_q         <= deny_d;
        end
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [NUM_PROD];
    logic [STOCK_W-1:0] stock_d [NUM_PROD];

    // producto_q still holds the vended index during the VEND cycle.
    always_comb begin
        stock_d = stock_q;
        if (state_q == ST_VEND) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                if (producto_q == SEL_W'(i) && stock_q[i] != '0) begin
                    stock_d[i] = stock_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            stock_q <= stock_d;
        end
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            sold_out[i] = (stock_q[i] == '0);
        end
    end
`else
    assign sold_out = '0;
`endif

    assign producto     = producto_q;
    assign listo        = listo_q;
    assign cambio       = cambio_q;
    assign cambio_valid = cambio_valid_q;
    assign credit       = credit_q;
    assign coin_rej     = coin_rej_q;
    assign deny         = deny_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed, table-driven bench for vending_ctrl_param (default parameters).
// Build with +define+VEND_STOCK_EN to exercise the stock-exhaustion sequence.
module tb_vending_ctrl_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] moneda = 2'b00;
    logic [1:0] seleccion = 2'b00;
    logic       sel_valid = 1'b0;
    logic       cancel = 1'b0;
    logic [1:0] producto;
    logic       listo;
    logic [1:0] cambio;
    logic       cambio_valid;
    logic [5:0] credit;
    logic       coin_rej;
    logic       deny;
    logic [3:0] sold_out;

    int n_cmp = 0;
    int n_bad = 0;

    vending_ctrl_param dut (
        .clk         (clk),
        .rst         (rst),
        .moneda      (moneda),
        .seleccion   (seleccion),
        .sel_valid   (sel_valid),
        .cancel      (cancel),
        .producto    (producto),
        .listo       (listo),
        .cambio      (cambio),
        .cambio_valid(cambio_valid),
        .credit      (credit),
        .coin_rej    (coin_rej),
        .deny        (deny),
        .sold_out    (sold_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] moneda;
        logic [1:0] sel;
        logic       sel_valid;
        logic       cancel;
        logic       rst;
        logic       listo;
        logic [1:0] prod;
        logic       cv;
        logic [1:0] cambio;
        logic [5:0] credit;
        logic       rej;
        logic       deny;
        logic [3:0] sold;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [1:0] m, input logic [1:0] s,
                                input logic sv, input logic c, input logic r,
                                input logic l, input logic [1:0] p, input logic cv,
                                input logic [1:0] cb, input logic [5:0] cr,
                                input logic rj, input logic dn, input logic [3:0] so);
        vec_t v;
        v.name = name; v.moneda = m; v.sel = s; v.sel_valid = sv; v.cancel = c; v.rst = r;
        v.listo = l; v.prod = p; v.cv = cv; v.cambio = cb; v.credit = cr;
        v.rej = rj; v.deny = dn; v.sold = so;
        return v;
    endfunction

    function automatic int coinUnits(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        moneda    = v.moneda;
        seleccion = v.sel;
        sel_valid = v.sel_valid;
        cancel    = v.cancel;
        rst       = v.rst;
        @(posedge clk);
        #1;
        moneda    = 2'b00;
        sel_valid = 1'b0;
        cancel    = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v);
        logic [17:0] got;
        logic [17:0] want;
        got  = {listo, producto, cambio_valid, cambio, credit, coin_rej, deny, sold_out};
        want = {v.listo, v.prod, v.cv, v.cambio, v.credit, v.rej, v.deny, v.sold};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got listo=%b prod=%0d cv=%b cambio=%b credit=%0d rej=%b deny=%b sold=%b, want listo=%b prod=%0d cv=%b cambio=%b credit=%0d rej=%b deny=%b sold=%b",
                     v.name, listo, producto, cambio_valid, cambio, credit, coin_rej, deny, sold_out,
                     v.listo, v.prod, v.cv, v.cambio, v.credit, v.rej, v.deny, v.sold);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        int  cnt;
        int  units;
        bit  done;
        logic [3:0] so_exp;

        //                name           mon   sel   sv c  r   listo prod cv cambio credit rej deny sold
        vecs.push_back(mk("reset",        2'b00, 2'd0, 0, 0, 1,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t1_coin2",     2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd2,  0, 0, 4'b0));
        vecs.push_back(mk("t1_coin4",     2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd4,  0, 0, 4'b0));
        vecs.push_back(mk("t1_vend0",     2'b00, 2'd0, 1, 0, 0,  1, 2'd0, 0, 2'b00, 6'd1,  0, 0, 4'b0));
        vecs.push_back(mk("t1_chg1",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 1, 2'b01, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t1_idle",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("idle_sel",     2'b00, 2'd1, 1, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 1, 4'b0));
        vecs.push_back(mk("idle_cancel",  2'b00, 2'd0, 0, 1, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t2_coin5",     2'b11, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd5,  0, 0, 4'b0));
        vecs.push_back(mk("t2_coin7",     2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd7,  0, 0, 4'b0));
        vecs.push_back(mk("t2_cancel",    2'b00, 2'd0, 0, 1, 0,  0, 2'd0, 1, 2'b11, 6'd2,  0, 0, 4'b0));
        vecs.push_back(mk("t2_chg2",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 1, 2'b10, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t2_idle",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t3_coin2",     2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd2,  0, 0, 4'b0));
        vecs.push_back(mk("t3_coin4",     2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd4,  0, 0, 4'b0));
        vecs.push_back(mk("t3_deny3",     2'b00, 2'd3, 1, 0, 0,  0, 2'd0, 0, 2'b00, 6'd4,  0, 1, 4'b0));
        vecs.push_back(mk("t3_coin9",     2'b11, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd9,  0, 0, 4'b0));
        vecs.push_back(mk("t3_vend3",     2'b00, 2'd3, 1, 0, 0,  1, 2'd3, 0, 2'b00, 6'd2,  0, 0, 4'b0));
        vecs.push_back(mk("t3_chg2",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 1, 2'b10, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t3_idle",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t4_coin5",     2'b11, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd5,  0, 0, 4'b0));
        vecs.push_back(mk("t4_coin10",    2'b11, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd10, 0, 0, 4'b0));
        vecs.push_back(mk("t4_coin12",    2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd12, 0, 0, 4'b0));
        vecs.push_back(mk("t4_coin14",    2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd14, 0, 0, 4'b0));
        vecs.push_back(mk("t4_sat_rej",   2'b11, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd14, 1, 0, 4'b0));
        vecs.push_back(mk("t4_vend_coin", 2'b01, 2'd2, 1, 0, 0,  1, 2'd2, 0, 2'b00, 6'd8,  1, 0, 4'b0));
        vecs.push_back(mk("t4_chg5",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 1, 2'b11, 6'd3,  0, 0, 4'b0));
        vecs.push_back(mk("t4_chg2",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 1, 2'b10, 6'd1,  0, 0, 4'b0));
        vecs.push_back(mk("t4_chg1",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 1, 2'b01, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t4_idle",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("ex_coin2",     2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd2,  0, 0, 4'b0));
        vecs.push_back(mk("ex_coin3",     2'b01, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd3,  0, 0, 4'b0));
        vecs.push_back(mk("ex_vend0",     2'b00, 2'd0, 1, 0, 0,  1, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("vend_rej",     2'b01, 2'd1, 1, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  1, 1, 4'b0));
        vecs.push_back(mk("ex_idle",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("pr_coin2",     2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd2,  0, 0, 4'b0));
        vecs.push_back(mk("pr_cancel",    2'b01, 2'd0, 1, 1, 0,  0, 2'd0, 1, 2'b10, 6'd0,  1, 0, 4'b0));
        vecs.push_back(mk("pr_idle",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("dc_coin2",     2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd2,  0, 0, 4'b0));
        vecs.push_back(mk("dc_deny_coin", 2'b01, 2'd3, 1, 0, 0,  0, 2'd0, 0, 2'b00, 6'd3,  0, 1, 4'b0));
        vecs.push_back(mk("dc_cancel",    2'b00, 2'd0, 0, 1, 0,  0, 2'd0, 1, 2'b10, 6'd1,  0, 0, 4'b0));
        vecs.push_back(mk("dc_chg1",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 1, 2'b01, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("dc_idle",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t6_coin5",     2'b11, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd5,  0, 0, 4'b0));
        vecs.push_back(mk("t6_coin7",     2'b10, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd7,  0, 0, 4'b0));
        vecs.push_back(mk("t6_coin8",     2'b01, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd8,  0, 0, 4'b0));
        vecs.push_back(mk("t6_cancel",    2'b00, 2'd0, 0, 1, 0,  0, 2'd0, 1, 2'b11, 6'd3,  0, 0, 4'b0));
        vecs.push_back(mk("t6_reset",     2'b10, 2'd0, 1, 0, 1,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t6_after",     2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t6_coin1",     2'b01, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd1,  0, 0, 4'b0));
        vecs.push_back(mk("t6_cancel1",   2'b00, 2'd0, 0, 1, 0,  0, 2'd0, 1, 2'b01, 6'd0,  0, 0, 4'b0));
        vecs.push_back(mk("t6_idle",      2'b00, 2'd0, 0, 0, 0,  0, 2'd0, 0, 2'b00, 6'd0,  0, 0, 4'b0));

        $display("[TB] running %0d table vectors", vecs.size());
        foreach (vecs[i]) runVec(vecs[i]);

        // Three exact-credit vends of product 1; with stock enabled its counter hits zero.
        for (int k = 0; k < 3; k++) begin
            runVec(mk("t5_coin2", 2'b10, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd2, 0, 0, 4'b0));
            runVec(mk("t5_coin4", 2'b10, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd4, 0, 0, 4'b0));
            runVec(mk("t5_vend1", 2'b00, 2'd1, 1, 0, 0, 1, 2'd1, 0, 2'b00, 6'd0, 0, 0, 4'b0));
`ifdef VEND_STOCK_EN
            so_exp = (k == 2) ? 4'b0010 : 4'b0000;
`else
            so_exp = 4'b0000;
`endif
            runVec(mk("t5_after", 2'b00, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd0, 0, 0, so_exp));
        end
        runVec(mk("t5_coin2b", 2'b10, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd2, 0, 0, so_exp));
        runVec(mk("t5_coin4b", 2'b10, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd4, 0, 0, so_exp));
`ifdef VEND_STOCK_EN
        runVec(mk("t5_soldout_deny", 2'b00, 2'd1, 1, 0, 0, 0, 2'd0, 0, 2'b00, 6'd4, 0, 1, 4'b0010));
        runVec(mk("t5_refund2a",     2'b00, 2'd0, 0, 1, 0, 0, 2'd0, 1, 2'b10, 6'd2, 0, 0, 4'b0010));
        runVec(mk("t5_refund2b",     2'b00, 2'd0, 0, 0, 0, 0, 2'd0, 1, 2'b10, 6'd0, 0, 0, 4'b0010));
        runVec(mk("t5_idle",         2'b00, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd0, 0, 0, 4'b0010));
        runVec(mk("t5_reload",       2'b00, 2'd0, 0, 0, 1, 0, 2'd0, 0, 2'b00, 6'd0, 0, 0, 4'b0000));
`else
        runVec(mk("t5_unlimited",    2'b00, 2'd1, 1, 0, 0, 1, 2'd1, 0, 2'b00, 6'd0, 0, 0, 4'b0));
        runVec(mk("t5_idle",         2'b00, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd0, 0, 0, 4'b0));
`endif

        // Refund of 8 units: count returned coins under a cycle budget.
        runVec(mk("rf_coin5", 2'b11, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd5, 0, 0, 4'b0));
        runVec(mk("rf_coin7", 2'b10, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd7, 0, 0, 4'b0));
        runVec(mk("rf_coin8", 2'b01, 2'd0, 0, 0, 0, 0, 2'd0, 0, 2'b00, 6'd8, 0, 0, 4'b0));
        @(negedge clk);
        cancel = 1'b1;
        cnt   = 0;
        units = 0;
        done  = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(posedge clk);
            #1;
            cancel = 1'b0;
            if (cambio_valid) begin
                cnt++;
                units += coinUnits(cambio);
            end else if (credit == 6'd0) begin
                done = 1'b1;
            end
        end
        checkValue("refund_done_in_budget", int'(done), 1);
        checkValue("refund_coin_count", cnt, 3);
        checkValue("refund_units", units, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
